// File: rtl/pwm_gen_if.sv
// PWM generator bus: upstream count/duty controls in,
// registered PWM, wrap pulse and period tally out.
interface pwm_gen_if #(
  parameter int N = 4,
  parameter int P = 8
);
  logic [N-1:0] count;
  logic         enable;
  logic [N-1:0] duty;
  logic         duty_load;
  logic         pwm;
  logic         wrap;
  logic         pending;
  logic [P-1:0] periods;

  modport master (
    output count, enable, duty, duty_load,
    input  pwm, wrap, pending, periods
  );

  modport slave (
    input  count, enable, duty, duty_load,
    output pwm, wrap, pending, periods
  );
endinterface

// File: rtl/pwm_gen.sv
// Registered PWM driven by an upstream up-counter, with
// shadowed duty applied only on a genuine period wrap.
module pwm_gen #(
  parameter int N = 4,
  parameter int P = 8
) (
  input logic   clk,
  input logic   rst,
  pwm_gen_if.slave bus
);

  logic [N-1:0] count_prev;
  logic [N-1:0] shadow;
  logic [N-1:0] active;
  logic         pending_q;
  logic         pwm_q;
  logic         wrap_q;
  logic [P-1:0] periods_q;

  logic         wrap_det;
  logic [N-1:0] eff;

  // Only a max->zero step under enable counts as a wrap.
  assign wrap_det = bus.enable
                 && (count_prev == '1)
                 && (bus.count == '0);

  always_comb begin
    eff = active;
    if (wrap_det) begin
      if (bus.duty_load) eff = bus.duty;
      else if (pending_q) eff = shadow;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_prev <= '0;
      shadow     <= '0;
      active     <= '0;
      pending_q  <= 1'b0;
      pwm_q      <= 1'b0;
      wrap_q     <= 1'b0;
      periods_q  <= '0;
    end else begin
      count_prev <= bus.count;
      if (bus.duty_load && !wrap_det) begin
        shadow    <= bus.duty;
        pending_q <= 1'b1;
      end
      if (wrap_det) begin
        active    <= eff;
        pending_q <= 1'b0;
      end
      pwm_q     <= bus.enable && (bus.count < eff);
      wrap_q    <= wrap_det;
      periods_q <= periods_q + P'(wrap_det);
    end
  end

  assign bus.pwm     = pwm_q;
  assign bus.wrap    = wrap_q;
  assign bus.pending = pending_q;
  assign bus.periods = periods_q;

endmodule
